fib_arbiter: RTL

Round-robin arbiter that shares one fib unit between N requesters. Each requester has its own valid/ready request and response channels. The block serialises requests to the fib unit with at most one in flight and routes each result back to its requester. Operands whose result would overflow 32 bits are rejected locally with an error response and are never sent to the fib unit.

---
 rtl/fib_arb_pkg.sv | 20 ++
 rtl/rr_pick.sv | 37 +++
 rtl/fib_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fib_arb_pkg.sv
// Shared definitions for the fib_arbiter block.
//   state_t     : arbiter FSM states
//   FIB_OP_W    : operand width of the shared fib unit
//   FIB_RES_W   : result width of the shared fib unit
//   FIB_MAX_OP  : largest operand whose Fibonacci number fits FIB_RES_W
package fib_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam int FIB_OP_W   = 8;
    localparam int FIB_RES_W  = 32;
    // fib(47) = 2971215073 is the last value below 2^32.
    localparam int FIB_MAX_OP = 47;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker.
//   req    : request vector, one bit per requester
//   ptr    : index of the highest-priority requester this round
//   any    : at least one request is set
//   idx    : index of the winner (0 when any is low)
//   onehot : one-hot winner vector (0 when any is low)
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic [N-1:0]     onehot
);

    logic [IDX_W-1:0] pos;

    // Walk the requesters starting at ptr and wrapping modulo N;
    // the first set bit wins.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        onehot = '0;
        pos    = '0;
        for (int k = 0; k < N; k++) begin
            pos = IDX_W'((int'(ptr) + k) % N);
            if (!any && req[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fib_arbiter.sv
// Round-robin arbiter sharing one fib unit between N_REQ requesters.
// One transaction is in flight at a time; operands above MAX_OP are
// answered locally with an error response and never reach the fib unit.
//   clk, rst     : clock, asynchronous active-high reset
//   req_vld/rdy  : per-requester request handshake, req_op packed operands
//   rsp_vld/rdy  : per-requester response handshake
//   rsp_data/err : shared response payload and overflow flag
//   fib_*        : request/result handshakes towards the fib unit
//   busy         : high whenever the FSM is not IDLE
//   grant_id     : owner of the current or most recent transaction
module fib_arbiter
    import fib_arb_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int OP_W   = FIB_OP_W,
    parameter int RES_W  = FIB_RES_W,
    parameter int MAX_OP = FIB_MAX_OP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_vld,
    output logic [N_REQ-1:0]           req_rdy,
    input  logic [N_REQ*OP_W-1:0]      req_op,
    output logic [N_REQ-1:0]           rsp_vld,
    input  logic [N_REQ-1:0]           rsp_rdy,
    output logic [RES_W-1:0]           rsp_data,
    output logic                       rsp_err,
    output logic [OP_W-1:0]            fib_in,
    output logic                       fib_vld_in,
    input  logic                       fib_rdy_in,
    input  logic [RES_W-1:0]           fib_out,
    input  logic                       fib_vld_out,
    output logic                       fib_rdy_out,
    output logic                       busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id
);

    localparam int ID_W = $clog2(N_REQ);

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   owner;
    logic [OP_W-1:0]   op_reg;
    logic [RES_W-1:0]  result;
    logic              err;

    logic              pick_any;
    logic [ID_W-1:0]   pick_idx;
    logic [N_REQ-1:0]  pick_oh;
    logic [OP_W-1:0]   pick_op;

    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] cur);
        if (cur == ID_W'(N_REQ - 1)) begin
            return '0;
        end
        return cur + 1'b1;
    endfunction

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req    (req_vld),
        .ptr    (rr_ptr),
        .any    (pick_any),
        .idx    (pick_idx),
        .onehot (pick_oh)
    );

    always_comb begin
        pick_op = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_idx == ID_W'(i)) begin
                pick_op = req_op[i*OP_W +: OP_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            owner  <= '0;
            op_reg <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner  <= pick_idx;
                        op_reg <= pick_op;
                        // Overflowing operands are answered immediately.
                        if (pick_op > OP_W'(MAX_OP)) begin
                            result <= '0;
                            err    <= 1'b1;
                            state  <= RESP;
                        end else begin
                            state  <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (fib_rdy_in) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (fib_vld_out) begin
                        result <= fib_out;
                        err    <= 1'b0;
                        state  <= RESP;
                    end
                end
                RESP: begin
                    // Only the owner's ready completes the response.
                    if (rsp_rdy[owner]) begin
                        rr_ptr <= next_ptr(owner);
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // req_rdy is combinational so the handshake completes in the accept
    // cycle; it is forced low while reset is asserted.
    assign req_rdy     = (state == IDLE && !rst) ? pick_oh : '0;
    assign fib_vld_in  = (state == ISSUE);
    assign fib_in      = (state == ISSUE) ? op_reg : '0;
    assign fib_rdy_out = (state == WAIT);
    assign rsp_vld     = (state == RESP) ? (N_REQ'(1) << owner) : '0;
    assign rsp_data    = result;
    assign rsp_err     = err;
    assign busy        = (state != IDLE);
    assign grant_id    = owner;

endmodule
